// File: rtl/fetch_unit_pkg.sv
// Shared constants and redirect encoding for the instruction fetch stage.
package fetch_unit_pkg;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_INC = 4;

    // Branch offsets count words, so they are scaled to bytes by this shift
    localparam int unsigned BR_SHIFT = 2;

    // Default fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Which redirect source steers the PC this cycle
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2
    } redirect_e;

    // An absolute jump outranks a taken branch raised in the same cycle
    function automatic redirect_e redirect_select(input logic jump, input logic taken);
        if (jump) begin
            return REDIR_JUMP;
        end else if (taken) begin
            return REDIR_BRANCH;
        end
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instruction} with flush, push, pop and count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties the FIFO without touching storage
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single outstanding memory request, prefetch FIFO and branch/jump redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                DEPTH    = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              B,
    input  logic              Z,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [31:0]       br_offset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    req_pc;
    logic                 outstanding;
    logic                 drop;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 response;
    logic                 push;
    logic                 pop;
    logic                 redirect;
    redirect_e            redirect_kind;
    logic [ADDR_W+31:0]   offset_wide;
    logic [ADDR_W-1:0]    branch_target;
    logic [ADDR_W-1:0]    redirect_target;
    logic [ADDR_W+31:0]   head;

    // Only one request may be in flight, so the FIFO-space test reduces to count < DEPTH
    assign imem_req  = Reset && !outstanding && (count < CNT_W'(DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    assign response  = imem_rvalid && outstanding;

    assign redirect_kind = redirect_select(jump, B && Z);
    assign redirect      = (redirect_kind != REDIR_NONE);

    // Responses that were flagged stale, or that land in a redirect cycle, never reach decode
    assign push       = response && !drop && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign inst_valid = (count != '0);
    assign inst       = head[31:0];
    assign inst_pc    = head[ADDR_W+31:32];

    // Redirect target: PC-relative branch with sign-extended word offset, or word-aligned jump
    always_comb begin
        offset_wide     = {{ADDR_W{br_offset[31]}}, br_offset} << BR_SHIFT;
        branch_target   = br_pc + ADDR_W'(PC_INC) + offset_wide[ADDR_W-1:0];
        redirect_target = pc;
        case (redirect_kind)
            REDIR_JUMP:   redirect_target = {jump_target[ADDR_W-1:2], 2'b00};
            REDIR_BRANCH: redirect_target = branch_target;
            default:      redirect_target = pc;
        endcase
    end

    // PC, in-flight request tracking and the flag that discards a response fetched before a redirect
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else begin
            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= pc;
            end else if (response) begin
                outstanding <= 1'b0;
            end

            if (redirect) begin
                drop <= (outstanding && !imem_rvalid) || accept;
            end else if (response && drop) begin
                drop <= 1'b0;
            end

            if (redirect) begin
                pc <= redirect_target;
            end else if (accept) begin
                pc <= pc + ADDR_W'(PC_INC);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 32)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .flush     (redirect),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

endmodule
